// File: rtl/mux_scan_seq_pkg.sv
// Shared definitions for the mux scan sequencer: FSM encodings and the
// select start/end indices derived from the scan direction.
package mux_scan_seq_pkg;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_SCAN = 1'b1;

   function automatic int start_idx(input int width, input bit msb_first);
      return msb_first ? width - 1 : 0;
   endfunction

   function automatic int end_idx(input int width, input bit msb_first);
      return msb_first ? 0 : width - 1;
   endfunction

endpackage

// File: rtl/mux8x1.sv
// Plain 8:1 combinational multiplexer, the consumer of the sequencer's
// data and select outputs.
module mux8x1 (
   input  logic [7:0] I,
   input  logic [2:0] S,
   output logic       O
);

   assign O = I[S];

endmodule

// File: rtl/mux_sel_cnt.sv
// Select counter: loads a fixed start value, steps up or down when enabled,
// and flags the end value explicitly rather than relying on overflow.
module mux_sel_cnt #(
   parameter int               SEL_W = 3,
   parameter bit               DOWN  = 1'b0,
   parameter logic [SEL_W-1:0] START = '0,
   parameter logic [SEL_W-1:0] STOP  = '1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   output logic [SEL_W-1:0] cnt,
   output logic             tc
);

   logic [SEL_W-1:0] cnt_q;
   logic [SEL_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = START;
      end else if (en) begin
         cnt_d = DOWN ? cnt_q - SEL_W'(1) : cnt_q + SEL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= START;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = (cnt_q == STOP);

endmodule

// File: rtl/mux_scan_seq.sv
// Word-to-serial sequencer: holds an accepted word on the mux inputs and
// walks the select once per accepted serial beat.
module mux_scan_seq
   import mux_scan_seq_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int SEL_W     = 3,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] mux_data,
   output logic [SEL_W-1:0] mux_sel,
   input  logic             mux_out,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_data,
   output logic             ser_last,
   output logic             busy
);

   localparam logic [SEL_W-1:0] START_IDX = SEL_W'(start_idx(WIDTH, MSB_FIRST));
   localparam logic [SEL_W-1:0] END_IDX   = SEL_W'(end_idx(WIDTH, MSB_FIRST));

   generate
      if (WIDTH != (1 << SEL_W)) begin : g_bad_width
         $error("mux_scan_seq: WIDTH must equal 2**SEL_W");
      end
   endgenerate

   logic             state_q;
   logic             state_d;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic             accept;
   logic             beat;
   logic             at_end;
   logic             cnt_load;
   logic             cnt_en;

   // Handshakes are gated by rst so nothing is offered or taken during reset.
   assign in_ready  = ~rst & (state_q == ST_IDLE);
   assign ser_valid = ~rst & (state_q == ST_SCAN);
   assign accept    = in_valid & in_ready;
   assign beat      = ser_valid & ser_ready;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      if (accept) begin
         state_d = ST_SCAN;
         data_d  = in_data;
      end else if (beat && at_end) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   // The select reloads both on accept and on the final beat so it always
   // rests at the start index while idle.
   assign cnt_load = accept | (beat & at_end);
   assign cnt_en   = beat & ~at_end;

   mux_sel_cnt #(
      .SEL_W (SEL_W),
      .DOWN  (MSB_FIRST),
      .START (START_IDX),
      .STOP  (END_IDX)
   ) u_sel_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (cnt_load),
      .en   (cnt_en),
      .cnt  (mux_sel),
      .tc   (at_end)
   );

   assign mux_data = data_q;
   assign ser_data = mux_out;
   assign ser_last = ser_valid & at_end;
   assign busy     = (state_q == ST_SCAN);

endmodule

// File: tb/tb_mux_scan_seq.sv
// Scoreboard bench: both scan directions run side by side on shared stimulus,
// each closed through its own 8:1 mux and checked against a word-level model.
module tb_mux_scan_seq;

   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       ser_ready = 1'b0;

   logic       in_ready[2];
   logic [7:0] mux_data[2];
   logic [2:0] mux_sel[2];
   logic       mux_out[2];
   logic       ser_valid[2];
   logic       ser_data[2];
   logic       ser_last[2];
   logic       busy[2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mux_scan_seq #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
      .in_data(in_data), .mux_data(mux_data[0]), .mux_sel(mux_sel[0]),
      .mux_out(mux_out[0]), .ser_valid(ser_valid[0]), .ser_ready(ser_ready),
      .ser_data(ser_data[0]), .ser_last(ser_last[0]), .busy(busy[0])
   );
   mux8x1 u_mux_lsb (.I(mux_data[0]), .S(mux_sel[0]), .O(mux_out[0]));

   mux_scan_seq #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
      .in_data(in_data), .mux_data(mux_data[1]), .mux_sel(mux_sel[1]),
      .mux_out(mux_out[1]), .ser_valid(ser_valid[1]), .ser_ready(ser_ready),
      .ser_data(ser_data[1]), .ser_last(ser_last[1]), .busy(busy[1])
   );
   mux8x1 u_mux_msb (.I(mux_data[1]), .S(mux_sel[1]), .O(mux_out[1]));

   // Reference model: bits remaining in the current word and the held word.
   int         rem = 0;
   int         acc_cnt = 0;
   logic [7:0] word_m = 8'h00;
   logic [1:0] q_lsb[$];   // {last, bit}
   logic [1:0] q_msb[$];

   always @(posedge clk) begin
      if (rst) begin
         rem    <= 0;
         word_m <= 8'h00;
         q_lsb.delete();
         q_msb.delete();
      end else if (rem == 0) begin
         if (in_valid) begin
            rem     <= W;
            word_m  <= in_data;
            acc_cnt <= acc_cnt + 1;
            for (int i = 0; i < W; i++) begin
               q_lsb.push_back({1'(i == W - 1), in_data[i]});
               q_msb.push_back({1'(i == W - 1), in_data[W - 1 - i]});
            end
         end
      end else if (ser_ready) begin
         rem <= rem - 1;
      end
   end

   task automatic chk(input string name, input int k, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s[%0s] t=%0t actual=%0d required=%0d", name,
                  (k == 0) ? "lsb" : "msb", $time, act, exp);
      end
   endtask

   // Monitor: compares control outputs every cycle and pops the scoreboard on beats.
   always @(negedge clk) begin
      logic [1:0] e;
      int pos;
      pos = (rem > 0) ? W - rem : 0;
      for (int k = 0; k < 2; k++) begin
         chk("in_ready", k, int'(in_ready[k]), int'(!rst && rem == 0));
         chk("ser_valid", k, int'(ser_valid[k]), int'(!rst && rem > 0));
         chk("busy", k, int'(busy[k]), int'(rem > 0));
         chk("mux_data", k, int'(mux_data[k]), int'(word_m));
         chk("mux_sel", k, int'(mux_sel[k]), (k == 0) ? pos : W - 1 - pos);
         if (!ser_valid[k]) chk("ser_last_idle", k, int'(ser_last[k]), 0);
         if (ser_valid[k] && ser_ready) begin
            if ((k == 0 ? q_lsb.size() : q_msb.size()) == 0) begin
               chk("beat_unexpected", k, 1, 0);
            end else begin
               e = (k == 0) ? q_lsb.pop_front() : q_msb.pop_front();
               chk("ser_data", k, int'(ser_data[k]), int'(e[0]));
               chk("ser_last", k, int'(ser_last[k]), int'(e[1]));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic ready_pat(input int mode, input int c);
      case (mode)
         0:       return 1'b1;
         1:       return 1'((c % 4 == 0) || (c % 4 == 3));
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   // Offer a word, wait for its accept, then drain it with the given ready pattern.
   // With hold set, in_valid stays high and nxt is presented just before the last beat.
   task automatic run_word(input logic [7:0] w, input int mode, input bit hold,
                           input logic [7:0] nxt);
      int a0;
      int n;
      a0 = acc_cnt;
      in_data  = w;
      in_valid = 1'b1;
      n = 0;
      while (acc_cnt == a0 && n < 40) begin
         step();
         n++;
      end
      if (acc_cnt == a0) chk("accept_timeout", 0, 1, 0);
      if (!hold) in_valid = 1'b0;
      in_data = 8'($urandom);
      n = 0;
      while (rem != 0 && n < 200) begin
         ser_ready = ready_pat(mode, n);
         if (hold && rem == 1) in_data = nxt;
         step();
         n++;
      end
      if (rem != 0) chk("drain_timeout", 0, 1, 0);
      $display("word %02h mode %0d done after %0d cycles", w, mode, n);
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      ser_ready = 1'b1;
      repeat (20) step();

      run_word(8'b10101010, 0, 1'b0, 8'h00);
      step();
      run_word(8'b11001100, 0, 1'b0, 8'h00);
      step();
      run_word(8'b10010001, 1, 1'b0, 8'h00);
      step();
      run_word(8'hFF, 0, 1'b1, 8'h00);
      run_word(8'h00, 0, 1'b0, 8'h00);
      step();

      // Reset after the third bit of a word
      in_data  = 8'b01101110;
      in_valid = 1'b1;
      ser_ready = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      $display("mid-word reset applied");
      run_word(8'b01101110, 0, 1'b0, 8'h00);

      for (int t = 0; t < 30; t++) begin
         run_word(8'($urandom), 2, 1'b0, 8'h00);
         repeat ($urandom_range(0, 2)) step();
      end

      ser_ready = 1'b1;
      repeat (3) step();
      chk("q_empty", 0, q_lsb.size(), 0);
      chk("q_empty", 1, q_msb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
